dom1_skinny_round_sched: RTL and testbench

Round scheduler for the first-order DOM-masked Skinny-128-384+ round datapath. It sequences one encryption as NUM_ROUNDS rounds of five one-hot phases and generates the 6-bit round-constant LFSR. It gates every round start on a fresh-randomness handshake with the mask PRNG, so no masked nonlinear layer runs without new randomness. It sits between the I/O control FSM (start/done) and the round datapath plus key/tweak schedules (en, load, rnd_cnst).

---
 rtl/dom1_skinny_round_sched.sv | 149 ++++++++++++++
 tb/tb_dom1_skinny_round_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dom1_skinny_round_sched.sv
// dom1_skinny_round_sched
//   Round scheduler for the first-order DOM-masked Skinny-128-384+ datapath.
//   It runs one encryption as NUM_ROUNDS rounds of five one-hot phases and
//   generates the 6-bit round-constant LFSR. No round starts until the mask
//   PRNG acknowledges fresh randomness.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   start      begin an encryption (sampled only in IDLE)
//   abort      synchronous abort back to IDLE, no done pulse
//   rnd_ack    PRNG has fresh randomness for the next round
//   rnd_req    randomness request for the round about to start
//   load       one-cycle pulse: datapath/schedules capture the input buffer
//   en[4:0]    one-hot phase enable, zero when no phase is issued
//   rnd_cnst   current round constant
//   round_idx  current round number
//   busy       high in LOAD, RUN and STALL
//   done       one-cycle pulse after the last phase of the last round
//
// state | meaning
// IDLE  | waiting for start; round_idx/rnd_cnst keep their last values
// LOAD  | input buffer capture, first randomness request
// RUN   | issuing phase ph of round round_idx
// STALL | waiting for rnd_ack before the next round, nothing issued
// DONE  | one-cycle completion pulse

module dom1_skinny_round_sched #(
  parameter int NUM_ROUNDS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       rnd_ack,
  output logic       rnd_req,
  output logic       load,
  output logic [4:0] en,
  output logic [5:0] rnd_cnst,
  output logic [5:0] round_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    STALL = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  state_t     state;
  logic [2:0] ph;
  logic       last_phase;
  logic       last_round;

  assign last_phase = (ph == 3'd4);
  assign last_round = (round_idx == LAST_ROUND);

  // Pure decode of registered state: a request is pending in LOAD, in STALL,
  // and in the final phase of every round that is followed by another round.
  assign rnd_req = (state == LOAD) || (state == STALL) ||
                   ((state == RUN) && last_phase && !last_round);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ph        <= 3'd0;
      round_idx <= 6'd0;
      rnd_cnst  <= 6'h01;
      en        <= 5'd0;
      load      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      en    <= 5'd0;
      load  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          en <= 5'd0;
          if (start) begin
            state <= LOAD;
            load  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          rnd_cnst  <= 6'h01;
          round_idx <= 6'd0;
          ph        <= 3'd0;
          if (rnd_ack) begin
            state <= RUN;
            en    <= 5'b00001;
          end else begin
            state <= STALL;
            en    <= 5'd0;
          end
        end
        RUN: begin
          if (!last_phase) begin
            ph <= ph + 3'd1;
            en <= {en[3:0], 1'b0};
          end else if (last_round) begin
            state <= DONE;
            en    <= 5'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            round_idx <= round_idx + 6'd1;
            // Skinny 6-bit round-constant LFSR
            rnd_cnst  <= {rnd_cnst[4:0], rnd_cnst[5] ^ rnd_cnst[4] ^ 1'b1};
            ph        <= 3'd0;
            if (rnd_ack) begin
              state <= RUN;
              en    <= 5'b00001;
            end else begin
              state <= STALL;
              en    <= 5'd0;
            end
          end
        end
        STALL: begin
          if (rnd_ack) begin
            state <= RUN;
            en    <= 5'b00001;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          en    <= 5'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dom1_skinny_round_sched.sv
module tb_dom1_skinny_round_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, rnd_ack;
  logic       rnd_req, load, busy, done;
  logic [4:0] en;
  logic [5:0] rnd_cnst, round_idx;

  logic       start1, abort1, rnd_ack1;
  logic       rnd_req1, load1, busy1, done1;
  logic [4:0] en1;
  logic [5:0] rnd_cnst1, round_idx1;

  int ncmp = 0;
  int nerr = 0;

  // Skinny round constants for rounds 0..39
  logic [5:0] rc_tab [40] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A};

  dom1_skinny_round_sched #(.NUM_ROUNDS(40)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rnd_ack(rnd_ack),
    .rnd_req(rnd_req), .load(load), .en(en), .rnd_cnst(rnd_cnst),
    .round_idx(round_idx), .busy(busy), .done(done));

  dom1_skinny_round_sched #(.NUM_ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .rnd_ack(rnd_ack1),
    .rnd_req(rnd_req1), .load(load1), .en(en1), .rnd_cnst(rnd_cnst1),
    .round_idx(round_idx1), .busy(busy1), .done(done1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".en"}, 32'(en), 0);
    chk({tag, ".load"}, 32'(load), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".rnd_req"}, 32'(rnd_req), 0);
    chk({tag, ".round_idx"}, 32'(round_idx), 0);
    chk({tag, ".rnd_cnst"}, 32'(rnd_cnst), 32'h01);
  endtask

  // One encryption from IDLE. rnd_ack is low in cycles s0..s0+n-1
  // (s0 must be a cycle with rnd_req=1), giving STALL in s0+1..s0+n.
  task automatic run_enc(input string tag, input int s0, input int n, input int done_cyc);
    int ce, k, r;
    start = 1'b1;
    rnd_ack = 1'b1;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      step();
      start = 1'b0;
      rnd_ack = !(c >= s0 && c < s0 + n);
      if (c == done_cyc) begin
        chk({tag, ".done_pulse"}, 32'(done), 1);
        chk({tag, ".busy_at_done"}, 32'(busy), 0);
        chk({tag, ".en_at_done"}, 32'(en), 0);
        chk({tag, ".req_at_done"}, 32'(rnd_req), 0);
        chk({tag, ".final_cnst"}, 32'(rnd_cnst), 32'h1A);
      end else if (c > done_cyc) begin
        chk({tag, ".done_after"}, 32'(done), 0);
        chk({tag, ".busy_after"}, 32'(busy), 0);
      end else if (c > s0 && c <= s0 + n) begin
        chk({tag, ".stall_en"}, 32'(en), 0);
        chk({tag, ".stall_req"}, 32'(rnd_req), 1);
        chk({tag, ".stall_busy"}, 32'(busy), 1);
        chk({tag, ".stall_idx"}, 32'(round_idx), 32'((s0 - 1) / 5));
        chk({tag, ".stall_cnst"}, 32'(rnd_cnst), 32'(rc_tab[(s0 - 1) / 5]));
      end else begin
        ce = (c > s0 + n) ? c - n : c;
        chk({tag, ".done_low"}, 32'(done), 0);
        chk({tag, ".busy"}, 32'(busy), 1);
        if (ce == 1) begin
          chk({tag, ".load"}, 32'(load), 1);
          chk({tag, ".load_req"}, 32'(rnd_req), 1);
          chk({tag, ".load_en"}, 32'(en), 0);
        end else begin
          k = (ce - 2) % 5;
          r = (ce - 2) / 5;
          chk({tag, ".en"}, 32'(en), 32'(1 << k));
          chk({tag, ".load_low"}, 32'(load), 0);
          chk({tag, ".round_idx"}, 32'(round_idx), 32'(r));
          chk({tag, ".rnd_cnst"}, 32'(rnd_cnst), 32'(rc_tab[r]));
          chk({tag, ".req"}, 32'(rnd_req), 32'((k == 4 && r < 39) ? 1 : 0));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; rnd_ack = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; rnd_ack1 = 1'b1;
    step(); step(); step();
    chk_reset_vals("reset");
    rst = 1'b1;
    step();

    run_enc("nominal", 0, 0, 202);
    step();
    run_enc("stall_r5", 26, 3, 205);
    step();
    run_enc("stall_init", 1, 2, 204);
    step();

    // abort at round 10, phase 2 (cycle 54)
    start = 1'b1;
    for (int c = 1; c <= 54; c++) begin
      step();
      start = 1'b0;
    end
    chk("abort.pre_en", 32'(en), 32'h04);
    chk("abort.pre_idx", 32'(round_idx), 10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort.en", 32'(en), 0);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.load", 32'(load), 0);
    chk("abort.idx_hold", 32'(round_idx), 10);
    for (int c = 0; c < 5; c++) begin
      chk("abort.no_done", 32'(done), 0);
      chk("abort.idle_en", 32'(en), 0);
      step();
    end
    run_enc("after_abort", 0, 0, 202);
    step();

    // reset mid-run at round 20
    start = 1'b1;
    for (int c = 1; c <= 102; c++) begin
      step();
      start = 1'b0;
    end
    chk("midrst.pre_idx", 32'(round_idx), 20);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_reset_vals("midrst");

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort.load", 32'(load), 0);
    chk("start_abort.busy", 32'(busy), 0);
    step();
    chk("start_abort.load2", 32'(load), 0);

    // start while busy is ignored
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      start = 1'b0;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy.en", 32'(en), 32'h10);
    chk("start_busy.idx", 32'(round_idx), 3);
    chk("start_busy.load", 32'(load), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("start_busy.abort_busy", 32'(busy), 0);
    step();

    // single-round instance; start during DONE is ignored
    start1 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      start1 = 1'b0;
      if (c == 1) begin
        chk("r1.load", 32'(load1), 1);
        chk("r1.load_req", 32'(rnd_req1), 1);
      end else if (c <= 6) begin
        chk("r1.en", 32'(en1), 32'(1 << (c - 2)));
        chk("r1.req_low", 32'(rnd_req1), 0);
        chk("r1.cnst", 32'(rnd_cnst1), 32'h01);
        chk("r1.done_low", 32'(done1), 0);
      end else if (c == 7) begin
        chk("r1.done", 32'(done1), 1);
        chk("r1.busy_done", 32'(busy1), 0);
        chk("r1.cnst_done", 32'(rnd_cnst1), 32'h01);
        start1 = 1'b1;
      end else begin
        chk("r1.start_in_done.load", 32'(load1), 0);
        chk("r1.start_in_done.busy", 32'(busy1), 0);
        chk("r1.done_after", 32'(done1), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
